// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// mux_4x1_rr_arbiter_pkg: FSM state encoding and grant decode helper shared by the arbiter.
package mux_4x1_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4x1_rr_arbiter_if.sv
// mux_4x1_rr_arbiter_if: requester/consumer side bundle of the shared output channel.
interface mux_4x1_rr_arbiter_if #(parameter int BITS = 4);

    logic [3:0]      req;
    logic [BITS-1:0] d [4];
    logic            out_ready;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            timeout;
    logic            busy;

    modport master (
        output req, d, out_ready,
        input  grant, sel, out_data, out_valid, timeout, busy
    );

    modport slave (
        input  req, d, out_ready,
        output grant, sel, out_data, out_valid, timeout, busy
    );

endinterface

// File: rtl/mux_4x1_rr_arbiter_mux.sv
// mux_4x1: plain combinational 4:1 data selector.
module mux_4x1 #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] i_d0,
    input  logic [BITS-1:0] i_d1,
    input  logic [BITS-1:0] i_d2,
    input  logic [BITS-1:0] i_d3,
    input  logic [1:0]      i_sel,
    output logic [BITS-1:0] o_mux_out
);

    always_comb
        o_mux_out = i_sel[1] ? (i_sel[0] ? i_d3 : i_d2) : (i_sel[0] ? i_d1 : i_d0);

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin owner of one output channel among four requesters,
// holding the grant until accept, withdraw or hold timeout.
module mux_4x1_rr_arbiter
    import mux_4x1_rr_arbiter_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int MAX_HOLD = 15
) (
    input logic                 i_clk,
    input logic                 i_rst,
    mux_4x1_rr_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    state_t          r_state;
    logic [1:0]      r_last;
    logic [1:0]      r_sel;
    logic [3:0]      r_grant;
    logic            r_valid;
    logic            r_timeout;
    logic [CW-1:0]   r_hold;
    logic [1:0]      w_base;
    logic [3:0]      w_rot;
    logic [1:0]      w_off;
    logic [1:0]      w_win;
    logic            w_hold_end;
    logic [BITS-1:0] w_out;

    // Rotate requests so index 0 is the slot just after the last owner; the 2-bit add wraps.
    always_comb begin
        w_base     = r_last + 2'd1;
        w_rot      = {bus.req[w_base + 2'd3], bus.req[w_base + 2'd2],
                      bus.req[w_base + 2'd1], bus.req[w_base]};
        w_off      = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_win      = w_base + w_off;
        w_hold_end = (r_hold == CW'(MAX_HOLD - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 2'd3;
            r_sel     <= 2'd0;
            r_grant   <= 4'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (|bus.req) begin
                    r_sel   <= w_win;
                    r_grant <= onehot(w_win);
                    r_valid <= 1'b1;
                    r_hold  <= '0;
                    r_state <= ST_GRANT;
                end else begin
                    r_grant <= 4'b0;
                end
            end else if (bus.out_ready || !bus.req[r_sel] || w_hold_end) begin
                r_last    <= r_sel;
                r_grant   <= 4'b0;
                r_valid   <= 1'b0;
                r_state   <= ST_IDLE;
                r_timeout <= !bus.out_ready && bus.req[r_sel] && w_hold_end;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    mux_4x1 #(.BITS(BITS)) u_mux (
        .i_d0      (bus.d[0]),
        .i_d1      (bus.d[1]),
        .i_d2      (bus.d[2]),
        .i_d3      (bus.d[3]),
        .i_sel     (r_sel),
        .o_mux_out (w_out)
    );

    assign bus.out_data  = w_out;
    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// tb_mux_4x1_rr_arbiter: directed checks of grant order, transfer, withdraw, timeout and reset.
module tb_mux_4x1_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mux_4x1_rr_arbiter_if #(.BITS(4)) bus ();

    mux_4x1_rr_arbiter #(.BITS(4), .MAX_HOLD(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, {4'b0, bus.grant}, 8'h00);
        check({tag, ".valid"}, {7'b0, bus.out_valid}, 8'h00);
        check({tag, ".busy"}, {7'b0, bus.busy}, 8'h00);
    endtask

    initial begin
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req = 4'b0;
        bus.out_ready = 1'b0;
        bus.d[0] = 4'hA;
        bus.d[1] = 4'h5;
        bus.d[2] = 4'h3;
        bus.d[3] = 4'hC;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset.sel", {6'b0, bus.sel}, 8'h00);
        check("reset.timeout", {7'b0, bus.timeout}, 8'h00);
        // single requester with consumer ready
        bus.req = 4'b0001;
        bus.out_ready = 1'b1;
        step();
        check("t1.grant", {4'b0, bus.grant}, 8'h01);
        check("t1.sel", {6'b0, bus.sel}, 8'h00);
        check("t1.data", {4'b0, bus.out_data}, 8'h0A);
        check("t1.valid", {7'b0, bus.out_valid}, 8'h01);
        check("t1.busy", {7'b0, bus.busy}, 8'h01);
        bus.req = 4'b0;
        step();
        check_idle("t1.done");
        // full rotation from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t2.grant%0d", i), {4'b0, bus.grant}, {4'b0, exp_g[i]});
            step();
            check($sformatf("t2.gap%0d", i), {4'b0, bus.grant}, 8'h00);
        end
        check("t2.lastdata", {4'b0, bus.out_data}, 8'h0A);
        // wrap: make requester 1 the last owner, then 0 and 1 both request
        bus.req = 4'b0010;
        step();
        check("t3.pre", {4'b0, bus.grant}, 8'h02);
        step();
        bus.req = 4'b0011;
        step();
        check("t3.grant", {4'b0, bus.grant}, 8'h01);
        bus.req = 4'b0;
        step();
        check_idle("t3.done");
        // stalled consumer, hold timeout after 3 cycles in GRANT
        bus.req = 4'b0100;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4.hold%0d", i), {4'b0, bus.grant}, 8'h04);
            check($sformatf("t4.noto%0d", i), {7'b0, bus.timeout}, 8'h00);
        end
        check("t4.data", {4'b0, bus.out_data}, 8'h03);
        step();
        check("t4.timeout", {7'b0, bus.timeout}, 8'h01);
        check_idle("t4.abort");
        bus.req = 4'b0;
        step();
        check("t4.pulse", {7'b0, bus.timeout}, 8'h00);
        // withdraw: last=2 so requester 1 wins, then drops its request
        bus.req = 4'b0010;
        step();
        check("t5.grant", {4'b0, bus.grant}, 8'h02);
        bus.req = 4'b0101;
        step();
        check_idle("t5.drop");
        check("t5.noto", {7'b0, bus.timeout}, 8'h00);
        step();
        check("t5.next", {4'b0, bus.grant}, 8'h04);
        step();
        check("t5.held", {4'b0, bus.grant}, 8'h04);
        // reset in the middle of GRANT
        rst = 1'b1;
        step();
        check_idle("t6.reset");
        check("t6.sel", {6'b0, bus.sel}, 8'h00);
        check("t6.timeout", {7'b0, bus.timeout}, 8'h00);
        rst = 1'b0;
        bus.req = 4'b1001;
        step();
        check("t6.last3", {4'b0, bus.grant}, 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
